// File: rtl/rgb_filter_indicator_if.sv
// Switch/brightness inputs and LED/status outputs of the filter-select RGB indicator.
// The board-side driver uses master; the indicator itself uses slave.
interface rgb_filter_indicator_if #(
   parameter int NUM_FILTERS = 5,
   parameter int PWM_BITS    = 8
);
   localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

   logic [NUM_FILTERS-1:0] sw;
   logic [PWM_BITS-1:0]    brightness;
   logic [2:0]             color;
   logic [IDX_W-1:0]       filter_idx;
   logic                   valid;
   logic                   error;

   modport master (
      output sw, brightness,
      input  color, filter_idx, valid, error
   );

   modport slave (
      input  sw, brightness,
      output color, filter_idx, valid, error
   );
endinterface

// File: rtl/rgb_filter_indicator.sv
// Debounced one-hot filter-select decoder driving an active-low RGB LED, with
// PWM dimming and a blinking red indication for multi-hot selections.
module rgb_filter_indicator #(
   parameter int NUM_FILTERS   = 5,
   parameter int STABLE_CYCLES = 16,
   parameter int PWM_BITS      = 8,
   parameter int BLINK_CYCLES  = 25000000
) (
   input  logic                  clk,
   input  logic                  reset,
   rgb_filter_indicator_if.slave bus
);
   localparam int IDX_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
   localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
   localparam logic [2:0] LED_OFF = 3'b111;
   localparam logic [2:0] LED_RED = 3'b011;

   typedef enum logic [1:0] {MODE_OFF, MODE_SHOW, MODE_ERROR} mode_t;

   logic [NUM_FILTERS-1:0] sw_q_reg, sw_q_next;
   logic [STAB_W-1:0]      stab_cnt_reg, stab_cnt_next;
   logic [NUM_FILTERS-1:0] accepted_reg, accepted_next;
   logic [PWM_BITS-1:0]    pwm_cnt_reg, pwm_cnt_next;
   logic [PWM_BITS-1:0]    bright_q_reg, bright_q_next;
   logic [BLINK_W-1:0]     blink_cnt_reg, blink_cnt_next;
   logic                   blink_on_reg, blink_on_next;
   logic [2:0]             color_reg, color_next;
   logic [IDX_W-1:0]       filter_idx_reg, filter_idx_next;
   logic                   valid_reg, valid_next;
   logic                   error_reg, error_next;

   mode_t                  mode;
   logic [IDX_W-1:0]       sel_idx;
   logic [2:0]             base_color;
   logic [1:0]             hits;
   logic                   pwm_on;
   logic [2:0]             base_lut [NUM_FILTERS];

   // Colour wheel repeats every six filters.
   for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : g_lut
      localparam int M = gi % 6;
      assign base_lut[gi] = (M == 0) ? 3'b001 :
                            (M == 1) ? 3'b100 :
                            (M == 2) ? 3'b010 :
                            (M == 3) ? 3'b110 :
                            (M == 4) ? 3'b101 : 3'b000;
   end

   always_comb begin
      hits       = 2'd0;
      sel_idx    = '0;
      base_color = LED_OFF;
      for (int i = 0; i < NUM_FILTERS; i++) begin
         if (accepted_reg[i]) begin
            if (hits != 2'd2) hits = hits + 2'd1;
            sel_idx    = IDX_W'(i);
            base_color = base_lut[i];
         end
      end
      case (hits)
         2'd0:    mode = MODE_OFF;
         2'd1:    mode = MODE_SHOW;
         default: mode = MODE_ERROR;
      endcase
   end

   assign pwm_on = (bright_q_reg == PWM_MAX) || (pwm_cnt_reg < bright_q_reg);

   // Debounce: a switch change always restarts the count, even on the accept edge.
   always_comb begin
      sw_q_next     = sw_q_reg;
      stab_cnt_next = stab_cnt_reg;
      accepted_next = accepted_reg;
      if (bus.sw != sw_q_reg) begin
         sw_q_next     = bus.sw;
         stab_cnt_next = '0;
      end else begin
         if (stab_cnt_reg != STAB_W'(STABLE_CYCLES))
            stab_cnt_next = stab_cnt_reg + 1'b1;
         if (stab_cnt_reg == STAB_W'(STABLE_CYCLES - 1))
            accepted_next = sw_q_reg;
      end
   end

   always_comb begin
      pwm_cnt_next  = pwm_cnt_reg + 1'b1;
      bright_q_next = (pwm_cnt_reg == PWM_MAX) ? bus.brightness : bright_q_reg;
   end

   always_comb begin
      color_next      = LED_OFF;
      filter_idx_next = filter_idx_reg;
      valid_next      = 1'b0;
      error_next      = 1'b0;
      blink_cnt_next  = '0;
      blink_on_next   = 1'b1;
      case (mode)
         MODE_SHOW: begin
            filter_idx_next = sel_idx;
            valid_next      = 1'b1;
            if (pwm_on) color_next = base_color;
         end
         MODE_ERROR: begin
            error_next = 1'b1;
            if (blink_on_reg && pwm_on) color_next = LED_RED;
            if (blink_cnt_reg == BLINK_W'(BLINK_CYCLES - 1)) begin
               blink_cnt_next = '0;
               blink_on_next  = ~blink_on_reg;
            end else begin
               blink_cnt_next = blink_cnt_reg + 1'b1;
               blink_on_next  = blink_on_reg;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_q_reg       <= '0;
         stab_cnt_reg   <= '0;
         accepted_reg   <= '0;
         pwm_cnt_reg    <= '0;
         bright_q_reg   <= '1;
         blink_cnt_reg  <= '0;
         blink_on_reg   <= 1'b1;
         color_reg      <= LED_OFF;
         filter_idx_reg <= '0;
         valid_reg      <= 1'b0;
         error_reg      <= 1'b0;
      end else begin
         sw_q_reg       <= sw_q_next;
         stab_cnt_reg   <= stab_cnt_next;
         accepted_reg   <= accepted_next;
         pwm_cnt_reg    <= pwm_cnt_next;
         bright_q_reg   <= bright_q_next;
         blink_cnt_reg  <= blink_cnt_next;
         blink_on_reg   <= blink_on_next;
         color_reg      <= color_next;
         filter_idx_reg <= filter_idx_next;
         valid_reg      <= valid_next;
         error_reg      <= error_next;
      end
   end

   assign bus.color      = color_reg;
   assign bus.filter_idx = filter_idx_reg;
   assign bus.valid      = valid_reg;
   assign bus.error      = error_reg;
endmodule

// File: doc/rgb_filter_indicator.md
Name: rgb_filter_indicator

Overview:
Parametrised successor to the combinational filter-select RGB LED decoder. Maps a one-hot filter-select switch bank of NUM_FILTERS bits to an active-low common-anode RGB LED colour. Adds switch debouncing, PWM brightness dimming, and a blinking red error indication for illegal (multi-hot) selections. Sits between the board switches and the RGB LED pins, alongside the filter pipeline that consumes the same switches.

Parameters:
NUM_FILTERS, 5, width of switch bank; filter i selected by SW[i] alone
STABLE_CYCLES, 16, cycles SW must be unchanged before accepted (>=1)
PWM_BITS, 8, PWM counter and brightness width
BLINK_CYCLES, 25000000, half-period of error blink in clk cycles (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
SW  input  NUM_FILTERS  raw filter-select switches
brightness  input  PWM_BITS  LED duty; all-ones = fully on
color  output  3  active-low {R,G,B}; 3'b111 = off
filter_idx  output  $clog2(NUM_FILTERS) (min 1)  index of accepted one-hot filter
valid  output  1  1 when exactly one filter accepted
error  output  1  1 when accepted selection is multi-hot

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on posedge clk.
- Reset values: color=3'b111, filter_idx=0, valid=0, error=0. Internal state: sw_q=0, stab_cnt=0, accepted=0, pwm_cnt=0, bright_q=all-ones, blink_cnt=0, blink_on=1.
- Debounce, each edge:
  - If SW!=sw_q: sw_q<=SW, stab_cnt<=0.
  - Else: if stab_cnt!=STABLE_CYCLES, stab_cnt<=stab_cnt+1; if stab_cnt==STABLE_CYCLES-1, accepted<=sw_q.
  - SW stable from edge e0 (the edge that loads sw_q) reaches accepted at edge e0+STABLE_CYCLES.
  - Any change before then restarts the count. accepted never sees a glitch.
- Mode decode (combinational from accepted):
  - OFF when accepted==0.
  - SHOW when exactly one bit is set.
  - ERROR when two or more bits are set.
- Output registers are updated every edge from mode, so outputs lag accepted by 1 cycle:
  - OFF: color=3'b111, valid=0, error=0, filter_idx holds its previous value.
  - SHOW: filter_idx=i, valid=1, error=0.
    - Base colour by i mod 6: 0 YELLOW 001, 1 CYAN 100, 2 MAGENTA 010, 3 BLUE 110, 4 GREEN 101, 5 WHITE 000.
    - color=base when pwm_on, else 3'b111.
  - ERROR: valid=0, error=1, filter_idx holds. color=RED 3'b011 when (blink_on && pwm_on), else 3'b111.
- PWM:
  - pwm_cnt increments every cycle and wraps 2^PWM_BITS-1 -> 0.
  - bright_q<=brightness only on the edge where pwm_cnt==all-ones, so duty changes never occur mid-period.
  - pwm_on = (bright_q==all-ones) || (pwm_cnt < bright_q). bright_q==0 means always off.
- Blink:
  - Runs only in ERROR. blink_cnt counts 0..BLINK_CYCLES-1; at the wrap it returns to 0 and blink_on toggles.
  - On any edge where mode is not ERROR: blink_cnt<=0, blink_on<=1, so entry to ERROR always starts with a full lit half-period.
- Simultaneous events: a SW change on the accept edge has priority and restarts the count; the accept does not happen. Reset overrides everything.
- Reset mid-blink or mid-debounce returns all state to reset values; an already-stable SW is re-accepted STABLE_CYCLES edges after reset deasserts.
- No combinational path from any input to any output.

Test Plan:
Use STABLE_CYCLES=4, PWM_BITS=2, BLINK_CYCLES=3, brightness=3 unless stated.
1. Reset, then SW=5'b00001 held -> color stays 111 for 4 edges after the sw_q load; at edge 5 color=001, filter_idx=0, valid=1.
2. SW=00010 toggled to 00000 every 2 cycles for 20 cycles -> accepted never changes, color/valid unchanged. Then hold 00100 -> color=010 and filter_idx=2 after 5 edges.
3. Sweep SW=2**i, i=0..4, each held 10 cycles -> color 001,100,010,110,101 in turn; filter_idx=i; valid=1.
4. SW=5'b00011 held -> error=1, valid=0. color=011 for 3 cycles, then 111 for 3, repeating. Changing to 00000 -> color=111, error=0, and the blink restarts lit on the next error.
5. SW=00001 stable, brightness=1 -> over each 4-cycle PWM period color=001 for 1 cycle and 111 for 3. brightness=0 -> always 111. Changing brightness mid-period takes effect only from the next pwm_cnt=0.
6. Assert reset during ERROR blink -> next edge color=111, error=0, valid=0. Deassert with SW=00011 still held -> error=1 at edge 5 after release, and the blink starts lit.
